oc8051_cxrom_arb: RTL and testbench



---
 rtl/oc8051_cxrom_arb_if.sv | 30 +++
 rtl/oc8051_cxrom_arb.sv | 92 +++++++++
 tb/tb_oc8051_cxrom_arb.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/oc8051_cxrom_arb_if.sv
// Bus bundle between the fetch/aux requesters, the code-ROM arbiter and the ROM.
// The slave modport is the arbiter's view; master is the requester/ROM side.
interface oc8051_cxrom_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
) ();
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic          cpu_ack;
    logic [DW-1:0] cpu_data;
    logic          aux_req;
    logic [AW-1:0] aux_addr;
    logic          aux_gnt;
    logic          aux_ack;
    logic [DW-1:0] aux_data;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [7:0]    aux_stall;

    modport slave (
        input  cpu_req, cpu_addr, aux_req, aux_addr, rom_data,
        output cpu_gnt, cpu_ack, cpu_data, aux_gnt, aux_ack, aux_data, rom_addr, aux_stall
    );

    modport master (
        output cpu_req, cpu_addr, aux_req, aux_addr, rom_data,
        input  cpu_gnt, cpu_ack, cpu_data, aux_gnt, aux_ack, aux_data, rom_addr, aux_stall
    );
endinterface

// File: rtl/oc8051_cxrom_arb.sv
// Shares the combinational code ROM between CPU fetch and an auxiliary reader.
// Define OC8051_CXROM_ARB_FAIR_EN to force an aux grant after STARVE_LIMIT denied cycles.
module oc8051_cxrom_arb #(
    parameter int AW           = 16,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    oc8051_cxrom_arb_if.slave      bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        AUX  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic [DW-1:0] cpu_data_q, cpu_data_d;
    logic [DW-1:0] aux_data_q, aux_data_d;
    logic [7:0]    aux_stall_q, aux_stall_d;
    logic          force_aux;
    logic          cpu_gnt;
    logic          aux_gnt;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..255");
    end

`ifdef OC8051_CXROM_ARB_FAIR_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
    assign force_aux = bus.aux_req && (aux_stall_q >= STARVE_LIM);
`else
    assign force_aux = 1'b0;
`endif

    // Grants are held off while reset is asserted so the ROM address stays at 0.
    assign cpu_gnt = ~rst & bus.cpu_req & ~force_aux;
    assign aux_gnt = ~rst & bus.aux_req & (~bus.cpu_req | force_aux);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d     = IDLE;
        last_addr_d = last_addr_q;
        cpu_data_d  = cpu_data_q;
        aux_data_d  = aux_data_q;
        aux_stall_d = 8'd0;

        if (cpu_gnt) begin
            state_d     = CPU;
            last_addr_d = bus.cpu_addr;
            cpu_data_d  = bus.rom_data;
        end else if (aux_gnt) begin
            state_d     = AUX;
            last_addr_d = bus.aux_addr;
            aux_data_d  = bus.rom_data;
        end

        if (bus.aux_req && !aux_gnt && aux_stall_q != 8'hFF) begin
            aux_stall_d = aux_stall_q + 8'd1;
        end else if (bus.aux_req && !aux_gnt) begin
            aux_stall_d = aux_stall_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_addr_q <= '0;
            cpu_data_q  <= '0;
            aux_data_q  <= '0;
            aux_stall_q <= 8'd0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            cpu_data_q  <= cpu_data_d;
            aux_data_q  <= aux_data_d;
            aux_stall_q <= aux_stall_d;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.aux_gnt   = aux_gnt;
    assign bus.rom_addr  = cpu_gnt ? bus.cpu_addr : (aux_gnt ? bus.aux_addr : last_addr_q);
    assign bus.cpu_ack   = (state_q == CPU);
    assign bus.aux_ack   = (state_q == AUX);
    assign bus.cpu_data  = cpu_data_q;
    assign bus.aux_data  = aux_data_q;
    assign bus.aux_stall = aux_stall_q;
endmodule

// File: tb/tb_oc8051_cxrom_arb.sv
// Self-checking bench for oc8051_cxrom_arb: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_oc8051_cxrom_arb;
    localparam int STARVE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    oc8051_cxrom_arb_if #(.AW(16), .DW(32)) bus ();

    oc8051_cxrom_arb #(.AW(16), .DW(32), .STARVE_LIMIT(STARVE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    assign bus.rom_data = rom_fn(bus.rom_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what each port should see, derived from the grant rules.
    logic        m_cpu_ack = 1'b0, m_aux_ack = 1'b0;
    logic [31:0] m_cpu_data = '0, m_aux_data = '0;
    logic [15:0] m_last_addr = '0;
    int          m_stall = 0;
    logic        m_last_cg = 1'b0, m_last_ag = 1'b0;

    task automatic model_grant(output logic cg, output logic ag);
        logic force_aux;
`ifdef OC8051_CXROM_ARB_FAIR_EN
        force_aux = bus.aux_req && (m_stall >= STARVE);
`else
        force_aux = 1'b0;
`endif
        cg = !rst && bus.cpu_req && !force_aux;
        ag = !rst && bus.aux_req && (!bus.cpu_req || force_aux);
    endtask

    always @(posedge clk or posedge rst) begin
        logic cg, ag;
        if (rst) begin
            m_cpu_ack = 0; m_aux_ack = 0; m_cpu_data = '0; m_aux_data = '0;
            m_last_addr = '0; m_stall = 0; m_last_cg = 0; m_last_ag = 0;
        end else begin
            model_grant(cg, ag);
            m_cpu_ack = cg;
            m_aux_ack = ag;
            if (cg) begin
                m_cpu_data  = rom_fn(bus.cpu_addr);
                m_last_addr = bus.cpu_addr;
            end else if (ag) begin
                m_aux_data  = rom_fn(bus.aux_addr);
                m_last_addr = bus.aux_addr;
            end
            if (bus.aux_req && !ag) m_stall = (m_stall >= 255) ? 255 : m_stall + 1;
            else                    m_stall = 0;
            m_last_cg = cg;
            m_last_ag = ag;
        end
    end

    // Per-cycle compare on the falling edge, away from input changes and register updates.
    always @(negedge clk) begin
        logic cg, ag;
        logic [15:0] exp_addr;
        model_grant(cg, ag);
        exp_addr = cg ? bus.cpu_addr : (ag ? bus.aux_addr : m_last_addr);
        check("cpu_gnt",   bus.cpu_gnt,   cg);
        check("aux_gnt",   bus.aux_gnt,   ag);
        check("rom_addr",  bus.rom_addr,  exp_addr);
        check("cpu_ack",   bus.cpu_ack,   m_cpu_ack);
        check("aux_ack",   bus.aux_ack,   m_aux_ack);
        check("cpu_data",  bus.cpu_data,  m_cpu_data);
        check("aux_data",  bus.aux_data,  m_aux_data);
        check("aux_stall", bus.aux_stall, 64'(m_stall));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cpu_req = 0; bus.cpu_addr = '0; bus.aux_req = 0; bus.aux_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Single CPU read at 0x0010.
        cyc(); bus.cpu_req = 1; bus.cpu_addr = 16'h0010;
        #1 check("single_gnt", bus.cpu_gnt, 1); check("single_rom_addr", bus.rom_addr, 16'h0010);
        cyc(); bus.cpu_req = 0;
        #1 check("single_ack", bus.cpu_ack, 1); check("single_data", bus.cpu_data, 32'h5A4A_FFEF);
        cyc();
        #1 check("single_ack_drop", bus.cpu_ack, 0);

        // Back-to-back CPU reads 0..3.
        for (int i = 0; i < 5; i++) begin
            cyc();
            bus.cpu_req  = (i < 4);
            bus.cpu_addr = 16'(i);
            #1;
            if (i > 0) begin
                check("b2b_ack", bus.cpu_ack, 1);
                check("b2b_data", bus.cpu_data, rom_fn(16'(i - 1)));
                check("b2b_aux_ack", bus.aux_ack, 0);
            end
        end
        cyc(); bus.cpu_req = 0;

        // Contention with both requests held.
        bus.aux_addr = 16'h1234; bus.cpu_addr = 16'h0020;
`ifdef OC8051_CXROM_ARB_FAIR_EN
        for (int k = 0; k < 27; k++) begin
            cyc(); bus.cpu_req = 1; bus.aux_req = 1;
            #1;
            check("fair_aux_gnt", bus.aux_gnt, (k % 9) == 8);
            check("fair_cpu_gnt", bus.cpu_gnt, (k % 9) != 8);
            check("fair_stall", bus.aux_stall, 64'(k % 9));
        end
`else
        for (int k = 0; k < 20; k++) begin
            cyc(); bus.cpu_req = 1; bus.aux_req = 1;
            #1;
            check("starve_aux_gnt", bus.aux_gnt, 0);
            check("starve_stall", bus.aux_stall, 64'(k));
        end
        cyc(); bus.cpu_req = 0;
        #1 check("release_stall", bus.aux_stall, 20); check("release_aux_gnt", bus.aux_gnt, 1);
        check("release_rom_addr", bus.rom_addr, 16'h1234);
        cyc(); bus.aux_req = 0;
        #1 check("release_aux_ack", bus.aux_ack, 1); check("release_aux_data", bus.aux_data, 32'h486E_EDCB);
        check("release_stall_clr", bus.aux_stall, 0);
        // Saturation of the stall counter.
        for (int k = 0; k < 260; k++) begin
            cyc(); bus.cpu_req = 1; bus.aux_req = 1;
        end
        #1 check("stall_saturate", bus.aux_stall, 255);
`endif

        // Idle hold after an aux grant at 0x1234.
        cyc(); bus.cpu_req = 0; bus.aux_req = 1; bus.aux_addr = 16'h1234;
        #1 check("idle_aux_gnt", bus.aux_gnt, 1);
        cyc(); bus.aux_req = 0;
        #1 check("idle_aux_ack", bus.aux_ack, 1); check("idle_aux_data", bus.aux_data, 32'h486E_EDCB);
        for (int k = 0; k < 5; k++) begin
            cyc();
            #1 check("idle_rom_addr", bus.rom_addr, 16'h1234);
            check("idle_cpu_ack", bus.cpu_ack, 0); check("idle_aux_ack0", bus.aux_ack, 0);
        end

        // Asynchronous reset mid-cycle with a CPU ack pending.
        cyc(); bus.cpu_req = 1; bus.cpu_addr = 16'h0040;
        cyc();
        #1 check("pre_rst_ack", bus.cpu_ack, 1);
        #2 rst = 1;
        #1;
        check("rst_cpu_ack", bus.cpu_ack, 0);   check("rst_aux_ack", bus.aux_ack, 0);
        check("rst_cpu_data", bus.cpu_data, 0); check("rst_aux_data", bus.aux_data, 0);
        check("rst_stall", bus.aux_stall, 0);   check("rst_rom_addr", bus.rom_addr, 0);
        @(posedge clk);
        #6 rst = 0;
        #1 check("post_rst_gnt", bus.cpu_gnt, 1); check("post_rst_ack", bus.cpu_ack, 0);
        cyc();
        #1 check("post_rst_ack1", bus.cpu_ack, 1); check("post_rst_data", bus.cpu_data, 32'h5A1A_FFBF);
        cyc(); bus.cpu_req = 0;

        // Randomized traffic; requesters hold req/addr until granted.
        for (int n = 0; n < 3000; n++) begin
            int busy;
            busy = (n < 1500) ? 50 : 97;
            cyc();
            if (!(bus.cpu_req && !m_last_cg)) begin
                bus.cpu_req  = ($urandom_range(0, 99) < busy);
                bus.cpu_addr = 16'($urandom);
            end
            if (!(bus.aux_req && !m_last_ag)) begin
                bus.aux_req  = ($urandom_range(0, 99) < 40);
                bus.aux_addr = 16'($urandom);
            end
        end
        cyc(); bus.cpu_req = 0; bus.aux_req = 0;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
